uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin controller that shares one UART transmitter between `NUM_REQ` byte producers. It accepts one word per grant over a valid/ready handshake and drives the transmitter's `start`/`message`/`idle` interface. It holds `txMessage` stable until the transmitter returns to idle. It sits between the transmit-side clients and the single transmitter instance feeding the `tx` pin.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: word width; matches the transmitter's `DATA_WIDTH`.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in `WAIT_BUSY` (see Configuration).
- `IDW`, derived: `$clog2(NUM_REQ)`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rstN` in 1: reset, synchronous, active-low.
- `reqValid` in NUM_REQ: requester i has a word pending.
- `reqData` in NUM_REQ*DATA_WIDTH: word of requester i at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `reqReady` out NUM_REQ: one-hot; word of requester i accepted on this edge.
- `txMessage` out DATA_WIDTH: registered word to the transmitter.
- `txStart` out 1: one-cycle start pulse to the transmitter.
- `txIdle` in 1: transmitter idle indication.
- `grantId` out IDW: index of the last granted requester.
- `busy` out 1: high whenever state != `ARB`.
- `timeoutErr` out 1: sticky watchdog flag.

## Operation
- States are `ARB`, `START`, `WAIT_BUSY`, `WAIT_IDLE`.
- **ARB**
  - If `txIdle`=1 and any `reqValid`, the winner is the first requester with valid set, searching from `lastGrant+1` modulo NUM_REQ, ascending with wrap.
  - `reqReady[winner]`=1 combinationally in this cycle.
  - On the edge: `txMessage`<=word of the winner; `lastGrant`<=winner; `grantId`<=winner; go to `START`.
  - Otherwise stay in `ARB` with `reqReady`=0.
- **START**: `txStart`=1 for exactly this cycle. Next state is `WAIT_BUSY`.
- **WAIT_BUSY**: wait for `txIdle`=0, then go to `WAIT_IDLE`.
- **WAIT_IDLE**: wait for `txIdle`=1, then go to `ARB`.
- `txMessage` is held constant from the grant until the next grant; it never changes outside `ARB`.
- A requester keeps `reqValid`/`reqData` stable until it sees `reqReady`. A requester may drop `reqValid` before grant with no effect.
- A requester whose `reqValid` is still high after its own grant is treated as a new request. It competes with lowest priority in the next `ARB`.
- Requests are only accepted in `ARB`. All `reqReady` outputs are 0 in every other state.
- Reset (`rstN`=0 at an edge) values:
  - State `ARB`; `lastGrant`=NUM_REQ-1, so requester 0 wins first.
  - `txMessage`=0, `txStart`=0, `grantId`=0, `busy`=0, `timeoutErr`=0, watchdog counter 0.
- Reset mid-transfer abandons the word, which was already acked and is not retried. `reqReady` is forced 0 while `rstN`=0.

## Timing
- Valid seen in `ARB` at cycle N: `reqReady` in N, `txStart` in N+1, `WAIT_BUSY` from N+2.
- With a transmitter whose idle drops the cycle after start, `WAIT_IDLE` is entered at N+3.
- Back-to-back: `txIdle` rising seen in `WAIT_IDLE` at cycle M gives `ARB` at M+1. The next `reqReady` can occur at M+1.
- Minimum spacing between `txStart` pulses is therefore transmit time + 3 cycles.
- `txIdle`=0 while in `ARB` blocks grant. `reqReady` stays low until `txIdle`=1.
- Simultaneous requests: exactly one `reqReady` bit high per grant, never more than one.
- `busy`, `grantId` and `txMessage` are registered; `reqReady` is combinational from `reqValid`, `txIdle` and state.

## Configuration
- Macro: `UART_TX_ARBITER_TIMEOUT_EN`.
- **Defined**
  - A counter runs in `WAIT_BUSY`. It clears on entry and increments each cycle.
  - If it reaches `TIMEOUT_CYCLES`-1 while `txIdle` is still 1:
    - `timeoutErr`<=1, sticky until reset.
    - The state returns to `ARB`; the word is dropped.
  - Counter width is `$clog2(TIMEOUT_CYCLES)`.
- **Undefined**: no counter. `WAIT_BUSY` waits indefinitely. `timeoutErr` is tied to 0.

## Test plan
- Reset, then `reqValid`=0001, `reqData[7:0]`=0x55 -> `reqReady`=0001 in the same cycle, `txStart` one cycle later, `txMessage`=0x55 held until the transmitter goes idle again; `grantId`=0.
- All four requesters valid continuously with data 0xA0..0xA3 -> grants in order 0,1,2,3,0; each `txStart` occurs only after `txIdle` returned high.
- `reqValid`=1010 after a grant to 1 -> next grant goes to 3, then 1.
- `txIdle` held 0 in `ARB` with `reqValid`=0001 -> no `reqReady` until `txIdle`=1.
- `rstN`=0 during `WAIT_IDLE` -> the next cycle shows state `ARB`, `busy`=0, `txStart`=0, `txMessage`=0, and requester 0 wins first.
- With macro defined, `TIMEOUT_CYCLES`=16 and `txIdle` stuck at 1 after `txStart` -> `timeoutErr`=1 and state `ARB` after 16 `WAIT_BUSY` cycles; without the macro, `busy` stays 1 indefinitely.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin controller that lets NUM_REQ byte producers share a single UART
// transmitter. One word is accepted per grant over a valid/ready handshake.
// The word is registered onto txMessage, announced with a one-cycle txStart
// pulse, and held until the transmitter has gone busy and returned to idle.
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   rstN       - synchronous active-low reset
//   reqValid   - [NUM_REQ] requester i has a word pending
//   reqData    - [NUM_REQ*DATA_WIDTH] word of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reqReady   - [NUM_REQ] one-hot, combinational; word of requester i taken on this edge
//   txMessage  - [DATA_WIDTH] registered word to the transmitter
//   txStart    - one-cycle start pulse to the transmitter
//   txIdle     - transmitter idle indication
//   grantId    - [IDW] index of the last granted requester
//   busy       - high whenever the controller is not arbitrating
//   timeoutErr - sticky watchdog flag (constant 0 when the watchdog is absent)
//
// Build option:
//   UART_TX_ARBITER_TIMEOUT_EN - when defined, a watchdog abandons a transfer
//   whose transmitter never leaves idle within TIMEOUT_CYCLES cycles of start.
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDW            = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic [DATA_WIDTH-1:0]         txMessage,
    output logic                          txStart,
    input  logic                          txIdle,
    output logic [IDW-1:0]                grantId,
    output logic                          busy,
    output logic                          timeoutErr
);

    typedef enum logic [1:0] {
        ARB,
        START,
        WAIT_BUSY,
        WAIT_IDLE
    } state_t;

    localparam logic [IDW:0] NUM_REQ_W = (IDW+1)'(NUM_REQ);

    state_t                  state;
    state_t                  state_next;
    logic [IDW-1:0]          last_grant;
    logic [IDW:0]            cand;
    logic                    win_found;
    logic [IDW-1:0]          win_id;
    logic [DATA_WIDTH-1:0]   win_data;
    logic                    grant;

    // ------------------------------------------------------------------------
    // Round-robin search: first valid requester starting at last_grant+1,
    // ascending with wrap. The one-bit-wider candidate keeps the wrap exact
    // for NUM_REQ values that are not a power of two.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every
        // output a default first, so no path leaves a value unassigned and no
        // latch is inferred.
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + (IDW+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!win_found && reqValid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                win_data = reqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A busy transmitter blocks the grant even in ARB; rstN gates reqReady so
    // no requester sees an acknowledge for a word that reset would discard.
    assign grant    = rstN && (state == ARB) && txIdle && win_found;
    assign reqReady = grant ? (NUM_REQ'(1) << win_id) : '0;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int             WDW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    logic [WDW-1:0] wd_cnt;
    logic           tx_timeout;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        tx_timeout = 1'b0;
`endif
        unique case (state)
            ARB: begin
                if (grant) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!txIdle) begin
                    state_next = WAIT_IDLE;
                end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                // Transmitter never acknowledged the start: drop the word.
                else if (wd_cnt == WD_LAST) begin
                    state_next = ARB;
                    tx_timeout = 1'b1;
                end
`endif
            end
            WAIT_IDLE: begin
                if (txIdle) begin
                    state_next = ARB;
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and registered outputs. txStart and busy are loaded from the next
    // state so they are true flops that line up with the state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstN) begin
            state      <= ARB;
            last_grant <= IDW'(NUM_REQ - 1);
            txMessage  <= '0;
            txStart    <= 1'b0;
            grantId    <= '0;
            busy       <= 1'b0;
        end else begin
            state   <= state_next;
            txStart <= (state_next == START);
            busy    <= (state_next != ARB);
            if (grant) begin
                txMessage  <= win_data;
                last_grant <= win_id;
                grantId    <= win_id;
            end
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    // Held at zero outside WAIT_BUSY, so it reads zero on the first
    // WAIT_BUSY cycle and counts up from there.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wd_cnt     <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (state == WAIT_BUSY) begin
                wd_cnt <= wd_cnt + WDW'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (tx_timeout) begin
                timeoutErr <= 1'b1;
            end
        end
    end
`else
    assign timeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// Expected grants (requester id + word) are queued when a request pattern is
// set up and popped when the DUT raises reqReady; the popped entry is then
// compared against reqReady, txStart, txMessage and grantId. The bench plays
// the transmitter itself: idle drops the cycle after txStart and rises again
// after a chosen transmit length.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int IDW        = 2;

    typedef struct {
        int                    id;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;

    logic                          clk;
    logic                          rstN;
    logic [NUM_REQ-1:0]            reqValid;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]            reqReady;
    logic [DATA_WIDTH-1:0]         txMessage;
    logic                          txStart;
    logic                          txIdle;
    logic [IDW-1:0]                grantId;
    logic                          busy;
    logic                          timeoutErr;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_wait;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_WIDTH    (DATA_WIDTH),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .reqValid  (reqValid),
        .reqData   (reqData),
        .reqReady  (reqReady),
        .txMessage (txMessage),
        .txStart   (txStart),
        .txIdle    (txIdle),
        .grantId   (grantId),
        .busy      (busy),
        .timeoutErr(timeoutErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [DATA_WIDTH-1:0] v);
        reqData[idx*DATA_WIDTH +: DATA_WIDTH] = v;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    // Wait for the next grant in ARB and play one transfer through the
    // transmitter. Entered and left at a point just after a rising edge.
    task automatic serve(input int tx_len, input bit drop_after);
        int   waited;
        exp_t e;
        waited = 0;
        #1;
        while (reqReady == '0 && waited < 50) begin
            @(posedge clk); #2;
            waited++;
        end
        check("grant_seen", 32'(reqReady != '0), 1);
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (reqReady == '0 || sb.size() == 0) return;
        e = sb.pop_front();
        check("ready_onehot", 32'($onehot(reqReady)), 1);
        check("ready_id", 32'(reqReady), 32'(1) << e.id);
        check("busy_in_arb", 32'(busy), 0);

        @(posedge clk); #1;                       // START
        if (drop_after) reqValid[e.id] = 1'b0;
        check("start_pulse", 32'(txStart), 1);
        check("start_msg", 32'(txMessage), 32'(e.data));
        check("start_gid", 32'(grantId), 32'(e.id));
        check("start_busy", 32'(busy), 1);
        check("start_noready", 32'(reqReady), 0);
        txIdle = 1'b0;

        @(posedge clk); #1;                       // WAIT_BUSY
        check("wb_nostart", 32'(txStart), 0);
        check("wb_noready", 32'(reqReady), 0);
        for (int i = 0; i < tx_len; i++) begin
            @(posedge clk); #1;                   // WAIT_IDLE
            check("wi_msg_hold", 32'(txMessage), 32'(e.data));
            check("wi_noready", 32'(reqReady), 0);
            check("wi_busy", 32'(busy), 1);
        end
        txIdle = 1'b1;

        @(posedge clk); #1;                       // ARB
        check("back_arb", 32'(busy), 0);
        check("back_msg_hold", 32'(txMessage), 32'(e.data));
    endtask

    initial begin
        rstN     = 1'b0;
        reqValid = '1;
        reqData  = '0;
        txIdle   = 1'b1;

        // Reset state, with requests already pending.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ready", 32'(reqReady), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(txStart), 0);
        check("rst_msg", 32'(txMessage), 0);
        check("rst_gid", 32'(grantId), 0);
        check("rst_tmo", 32'(timeoutErr), 0);
        reqValid = '0;
        rstN     = 1'b1;
        @(posedge clk); #1;

        // Single request from requester 0.
        set_word(0, 8'h55);
        reqValid = 4'b0001;
        sb.push_back('{0, 8'h55});
        serve(3, 1'b1);

        // All requesters continuously valid: 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_word(i, 8'hA0 + 8'(i));
        reqValid = 4'b1111;
        sb.push_back('{0, 8'hA0});
        sb.push_back('{1, 8'hA1});
        sb.push_back('{2, 8'hA2});
        sb.push_back('{3, 8'hA3});
        sb.push_back('{0, 8'hA0});
        repeat (5) serve(2, 1'b0);

        // Sparse pattern 1010 after a grant to 0: 1, 3, 1.
        reqValid = 4'b1010;
        sb.push_back('{1, 8'hA1});
        sb.push_back('{3, 8'hA3});
        sb.push_back('{1, 8'hA1});
        repeat (3) serve(1, 1'b0);
        reqValid = '0;

        // Busy transmitter in ARB blocks the grant.
        txIdle = 1'b0;
        set_word(0, 8'h3C);
        reqValid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("blocked_ready", 32'(reqReady), 0);
            check("blocked_busy", 32'(busy), 0);
            @(posedge clk); #1;
        end
        txIdle = 1'b1;
        sb.push_back('{0, 8'h3C});
        serve(2, 1'b1);

        // Reset in WAIT_IDLE abandons the word; requester 0 wins first after.
        set_word(2, 8'h77);
        reqValid = 4'b0100;
        #1;
        check("mid_ready", 32'(reqReady), 32'b0100);
        @(posedge clk); #1;
        reqValid = '0;
        txIdle   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 1);
        rstN = 1'b0;
        set_word(0, 8'h11);
        reqValid = 4'b0001;
        #1;
        check("rstlow_ready", 32'(reqReady), 0);
        @(posedge clk); #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_start", 32'(txStart), 0);
        check("mid_rst_msg", 32'(txMessage), 0);
        check("mid_rst_gid", 32'(grantId), 0);
        rstN     = 1'b1;
        txIdle   = 1'b1;
        reqValid = 4'b0101;
        sb.push_back('{0, 8'h11});
        sb.push_back('{2, 8'h77});
        serve(1, 1'b1);
        serve(1, 1'b1);

        // Transmitter never leaves idle after start.
        set_word(0, 8'h99);
        reqValid = 4'b0001;
        #1;
        check("stuck_ready", 32'(reqReady), 1);
        @(posedge clk); #1;
        reqValid = '0;
        check("stuck_start", 32'(txStart), 1);
        n_wait = 0;
        do begin
            @(posedge clk); #1;
            n_wait++;
        end while (busy === 1'b1 && n_wait < 100);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        check("tmo_cycles", 32'(n_wait), 17);
        check("tmo_flag", 32'(timeoutErr), 1);
        check("tmo_msg", 32'(txMessage), 32'h99);
        repeat (3) @(posedge clk);
        #1;
        check("tmo_sticky", 32'(timeoutErr), 1);
`else
        check("notmo_cycles", 32'(n_wait), 100);
        check("notmo_busy", 32'(busy), 1);
        check("notmo_flag", 32'(timeoutErr), 0);
`endif

        check("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
